// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator.
//   MODE_*     : 2-bit per-channel mode codes
//   calc_div   : sysclk cycles per timebase tick
//   div_ok     : elaboration-time sanity check of the CLK_HZ/TICK_HZ pair
package led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    // True when tick_hz divides clk_hz with a ratio of at least 2.
    function automatic bit div_ok(input int unsigned clk_hz, input int unsigned tick_hz);
        if (tick_hz == 0) return 1'b0;
        if ((clk_hz % tick_hz) != 0) return 1'b0;
        return (clk_hz / tick_hz) >= 2;
    endfunction

    // Falls back to 2 on a bad pair so elaboration stays well-formed; div_ok flags the error.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        if (!div_ok(clk_hz, tick_hz)) return 2;
        return clk_hz / tick_hz;
    endfunction

    // Per-channel output select.
    function automatic logic led_sel(input logic [1:0] m, input logic phase, input logic pwm_on);
        logic r;
        case (m)
            MODE_OFF:   r = 1'b0;
            MODE_ON:    r = 1'b1;
            MODE_BLINK: r = phase;
            default:    r = pwm_on;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Timebase prescaler: counts 0..DIV-1 and emits a registered one-cycle pulse
// in the cycle after the count reaches DIV-1.
//   sysclk : clock
//   rst_n  : async active-low reset
//   tick   : one-cycle tick pulse
module led_tick_prescaler #(
    parameter int unsigned DIV = 2
) (
    input  logic sysclk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_d;

    // Wrap at DIV-1 and flag the wrap for the next cycle.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= tick_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / BREATHE.
// A shared prescaled tick drives a common blink phase and a triangular
// brightness ramp; breathe brightness is rendered by a free-running PWM.
//   sysclk      : clock
//   rst_n       : async active-low reset
//   mode        : 2 bits per channel, channel i at [2i+1:2i]
//   half_period : blink half-period in ticks (0 behaves as 1)
//   led         : registered LED drive, active-high
//   tick_o      : one-cycle pulse per timebase tick
// Optional: LED_PHASE_STAGGER_EN puts odd channels in antiphase.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned CLK_HZ   = 125000000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned PER_BITS = 16,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic [2*NUM_LEDS-1:0]   mode,
    input  logic [PER_BITS-1:0]     half_period,
    output logic [NUM_LEDS-1:0]     led,
    output logic                    tick_o
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
        $error("led_pattern_gen: TICK_HZ must divide CLK_HZ with a ratio of at least 2");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_bad_num
        $error("led_pattern_gen: NUM_LEDS must be in 1..32");
    end

    localparam logic [PWM_BITS-1:0] BR_MAX = '1;

    logic                tick;
    logic [PER_BITS-1:0] tick_cnt_q, tick_cnt_d;
    logic [PER_BITS-1:0] hp_lim;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] br_step;
    logic                dir_up_q, dir_up_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [NUM_LEDS-1:0] led_d;

    led_tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .tick   (tick)
    );

    assign tick_o = tick;

    // Wrap threshold; half_period of 0 behaves as 1.
    assign hp_lim = (half_period == '0) ? '0 : (half_period - PER_BITS'(1));

    // Blink timer: >= lets a shrunk half_period wrap on the next tick.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        if (tick) begin
            if (tick_cnt_q >= hp_lim) begin
                tick_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                tick_cnt_d = tick_cnt_q + PER_BITS'(1);
            end
        end
    end

    // Triangular ramp; direction flips on arrival at an endpoint so each
    // endpoint lasts exactly one tick.
    always_comb begin
        bright_d = bright_q;
        dir_up_d = dir_up_q;
        br_step  = dir_up_q ? (bright_q + PWM_BITS'(1)) : (bright_q - PWM_BITS'(1));
        if (tick) begin
            bright_d = br_step;
            if (br_step == BR_MAX) begin
                dir_up_d = 1'b0;
            end else if (br_step == '0) begin
                dir_up_d = 1'b1;
            end
        end
    end

    assign pwm_d = pwm_q + PWM_BITS'(1);

    // Output muxes use next-state phase/brightness so a tick and a mode
    // change sampled on the same edge land in the same output update.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic [1:0]          ch_mode;
        logic                ch_phase;
        logic [PWM_BITS-1:0] ch_bright;

        assign ch_mode = mode[2*i +: 2];
`ifdef LED_PHASE_STAGGER_EN
        if ((i % 2) == 1) begin : g_odd
            assign ch_phase  = ~phase_d;
            assign ch_bright = ~bright_d;
        end else begin : g_even
            assign ch_phase  = phase_d;
            assign ch_bright = bright_d;
        end
`else
        assign ch_phase  = phase_d;
        assign ch_bright = bright_d;
`endif
        assign led_d[i] = led_sel(ch_mode, ch_phase, (pwm_q < ch_bright));
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
            bright_q   <= '0;
            dir_up_q   <= 1'b1;
            pwm_q      <= '0;
            led        <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            bright_q   <= bright_d;
            dir_up_q   <= dir_up_d;
            pwm_q      <= pwm_d;
            led        <= led_d;
        end
    end

endmodule
